multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/aludec.sv | 33 +++
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared types and encodings for the multicycle MIPS controller.
// Rev 1.0
// ============================================================================
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_JREX    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_LB    = 6'b100000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [5:0] C_F_JR   = 6'b001000;
  localparam logic [5:0] C_F_JALR = 6'b001001;
  localparam logic [5:0] C_F_ADD  = 6'b100000;
  localparam logic [5:0] C_F_SUB  = 6'b100010;
  localparam logic [5:0] C_F_AND  = 6'b100100;
  localparam logic [5:0] C_F_OR   = 6'b100101;
  localparam logic [5:0] C_F_SLT  = 6'b101010;

  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  // States whose exit back to FETCH marks a completed instruction.
  function automatic logic is_retire_state(input state_t s);
    case (s)
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX,
      S_ADDIWB, S_JEX, S_JREX: is_retire_state = 1'b1;
      default:                 is_retire_state = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/aludec.sv
`default_nettype none
// ============================================================================
// aludec : maps aluop and R-type funct field to the 3-bit ALU operation.
// Rev 1.0
// ============================================================================
module aludec
  import mips_pkg::*;
(
  input  aluop_t       aluop,
  input  logic [5:0]   funct,
  output logic [2:0]   alucontrol
);

  always_comb begin
    alucontrol = C_ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = C_ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          C_F_ADD: alucontrol = C_ALU_ADD;
          C_F_SUB: alucontrol = C_ALU_SUB;
          C_F_AND: alucontrol = C_ALU_AND;
          C_F_OR:  alucontrol = C_ALU_OR;
          C_F_SLT: alucontrol = C_ALU_SLT;
          default: alucontrol = C_ALU_ADD;
        endcase
      end
      default: alucontrol = C_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : Moore FSM controller for a multicycle MIPS datapath with
//                   memory handshake and retired-instruction counter.
// Rev 1.0
// ============================================================================
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memready,
  output logic        iord,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        membyteread,
  output logic        linkpc,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;

  aluop_t      w_aluop;
  logic        w_irwrite;
  logic        w_pcwrite;
  logic        w_memwrite;
  logic        w_regwrite;
  logic        w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (is_retire_state(r_state) && (w_next == S_FETCH))
        r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_aluop     = ALUOP_ADD;
    w_irwrite   = 1'b0;
    w_pcwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    iord        = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    membyteread = 1'b0;
    linkpc      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;

    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = memready;
        w_pcwrite = memready;
        w_next    = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          C_OP_LW, C_OP_SW, C_OP_LB: w_next = S_MEMADR;
          C_OP_RTYPE: begin
            if ((funct == C_F_JR) || (funct == C_F_JALR))
              w_next = S_JREX;
            else
              w_next = S_RTYPEEX;
          end
          C_OP_BEQ:  w_next = S_BEQEX;
          C_OP_ADDI: w_next = S_ADDIEX;
          C_OP_J:    w_next = S_JEX;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == C_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord        = 1'b1;
        membyteread = (op == C_OP_LB);
        w_next      = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = memready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQEX: begin
        alusrca   = 1'b1;
        w_aluop   = ALUOP_SUB;
        pcsrc     = 2'b01;
        w_pcwrite = zero;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      S_JREX: begin
        pcsrc     = 2'b11;
        w_pcwrite = 1'b1;
        // jalr links the return address into rd
        if (funct == C_F_JALR) begin
          w_regwrite = 1'b1;
          regdst     = 1'b1;
          linkpc     = 1'b1;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  aludec u_aludec (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Architectural side effects are suppressed while reset is held.
  assign irwrite  = w_irwrite  & ~reset;
  assign pcwrite  = w_pcwrite  & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign illegal  = w_illegal  & ~reset;

  assign state   = r_state;
  assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : scoreboard bench for multicycle_ctrl.
// Rev 1.0
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        memready = 1'b0;
  logic        iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg;
  logic        membyteread, linkpc, alusrca, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .membyteread(membyteread), .linkpc(linkpc),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_cyc   = 0;

  // {iord,irwrite,pcwrite,memwrite,regwrite,regdst,memtoreg,membyteread,
  //  linkpc,alusrca,alusrcb,pcsrc,alucontrol,illegal}
  function automatic logic [17:0] mk(
    input logic a_iord, a_irw, a_pcw, a_memw, a_regw, a_rdst, a_m2r,
    input logic a_mbr, a_link, a_asa, input logic [1:0] a_asb, a_pcs,
    input logic [2:0] a_aluc, input logic a_ill);
    mk = {a_iord, a_irw, a_pcw, a_memw, a_regw, a_rdst, a_m2r, a_mbr,
          a_link, a_asa, a_asb, a_pcs, a_aluc, a_ill};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [17:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg,
             membyteread, linkpc, alusrca, alusrcb, pcsrc, alucontrol, illegal};
      n_total += 3;
      if (state === e.st) n_pass++;
      else $display("FAIL state cyc%0d got %0d want %0d", n_cyc, state, e.st);
      if (act === e.ctl) n_pass++;
      else $display("FAIL ctl cyc%0d got %b want %b", n_cyc, act, e.ctl);
      if (instret === e.ir) n_pass++;
      else $display("FAIL instret cyc%0d got %0d want %0d", n_cyc, instret, e.ir);
      n_cyc++;
    end
  end

  task automatic cyc(input logic rs, mr, z, input logic [5:0] o, f,
                     input logic [3:0] es, input logic [17:0] ec,
                     input logic [31:0] ei);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; memready = mr; zero = z; op = o; funct = f;
    e.st = es; e.ctl = ec; e.ir = ei;
    q.push_back(e);
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, LB = 6'b100000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] RT = 6'b000000, BAD = 6'b111111;
  localparam logic [5:0] JALR = 6'b001001, FAND = 6'b100100;

  initial begin
    logic [17:0] FET0, FET1, DEC, ILL, MADR, MRD, MRDB, MWB, MWR;
    logic [17:0] RTEX, RTWB, BEQ1, BEQ0, JLR, AWB, JEXV;
    FET0 = mk(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    FET1 = mk(0,1,1,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    DEC  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    ILL  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1);
    MADR = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    MRD  = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    MRDB = mk(1,0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010,0);
    MWB  = mk(0,0,0,0,1,0,1,0,0,0,2'b00,2'b00,3'b010,0);
    MWR  = mk(1,0,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    RTEX = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0);
    RTWB = mk(0,0,0,0,1,1,0,0,0,0,2'b00,2'b00,3'b010,0);
    BEQ1 = mk(0,0,1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0);
    BEQ0 = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0);
    JLR  = mk(0,0,1,0,1,1,0,0,1,0,2'b00,2'b11,3'b010,0);
    AWB  = mk(0,0,0,0,1,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    JEXV = mk(0,0,1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0);

    // reset: FETCH with write enables held low even though memready=1
    cyc(1,1,0,LW,0, 4'd0, FET0, 0);
    // lw, memready high throughout: 0,1,2,3,4,0
    cyc(0,1,0,LW,0, 4'd0, FET1, 0);
    cyc(0,1,0,LW,0, 4'd1, DEC,  0);
    cyc(0,1,0,LW,0, 4'd2, MADR, 0);
    cyc(0,1,0,LW,0, 4'd3, MRD,  0);
    cyc(0,1,0,LW,0, 4'd4, MWB,  0);
    // sw: memready low 3 cycles in MEMWR -> memwrite for 4 cycles
    cyc(0,1,0,SW,0, 4'd0, FET1, 1);
    cyc(0,1,0,SW,0, 4'd1, DEC,  1);
    cyc(0,1,0,SW,0, 4'd2, MADR, 1);
    cyc(0,0,0,SW,0, 4'd5, MWR,  1);
    cyc(0,0,0,SW,0, 4'd5, MWR,  1);
    cyc(0,0,0,SW,0, 4'd5, MWR,  1);
    cyc(0,1,0,SW,0, 4'd5, MWR,  1);
    // beq taken then not taken
    cyc(0,1,1,BEQ,0, 4'd0, FET1, 2);
    cyc(0,1,1,BEQ,0, 4'd1, DEC,  2);
    cyc(0,1,1,BEQ,0, 4'd8, BEQ1, 2);
    cyc(0,1,0,BEQ,0, 4'd0, FET1, 3);
    cyc(0,1,0,BEQ,0, 4'd1, DEC,  3);
    cyc(0,1,0,BEQ,0, 4'd8, BEQ0, 3);
    // jalr
    cyc(0,1,0,RT,JALR, 4'd0,  FET1, 4);
    cyc(0,1,0,RT,JALR, 4'd1,  DEC,  4);
    cyc(0,1,0,RT,JALR, 4'd12, JLR,  4);
    // R-type and
    cyc(0,1,0,RT,FAND, 4'd0, FET1, 5);
    cyc(0,1,0,RT,FAND, 4'd1, DEC,  5);
    cyc(0,1,0,RT,FAND, 4'd6, RTEX, 5);
    cyc(0,1,0,RT,FAND, 4'd7, RTWB, 5);
    // illegal opcode: no retire
    cyc(0,1,0,BAD,0, 4'd0, FET1, 6);
    cyc(0,1,0,BAD,0, 4'd1, ILL,  6);
    // lb, FETCH stall, then reset while stalled in MEMRD
    cyc(0,0,0,LB,0, 4'd0, FET0, 6);
    cyc(0,1,0,LB,0, 4'd0, FET1, 6);
    cyc(0,1,0,LB,0, 4'd1, DEC,  6);
    cyc(0,1,0,LB,0, 4'd2, MADR, 6);
    cyc(0,0,0,LB,0, 4'd3, MRDB, 6);
    cyc(1,0,0,LB,0, 4'd3, MRDB, 6);
    cyc(1,1,0,LB,0, 4'd0, FET0, 0);
    // addi then j after reset
    cyc(0,1,0,ADDI,0, 4'd0,  FET1, 0);
    cyc(0,1,0,ADDI,0, 4'd1,  DEC,  0);
    cyc(0,1,0,ADDI,0, 4'd9,  MADR, 0);
    cyc(0,1,0,ADDI,0, 4'd10, AWB,  0);
    cyc(0,1,0,J,0,    4'd0,  FET1, 1);
    cyc(0,1,0,J,0,    4'd1,  DEC,  1);
    cyc(0,1,0,J,0,    4'd11, JEXV, 1);
    cyc(0,0,0,RT,0,   4'd0,  FET0, 2);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
